// File: rtl/fifo_sync_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_buf_pkg
// Description : Shared defaults and read-mode encodings for the synchronous
//               FIFO buffer; also reused by DSP filter blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_sync_buf_pkg;

    // Default geometry: 8-bit words, 8 entries, 4-bit pointers (3 address + wrap)
    localparam int D_SIZE_DEF  = 8;
    localparam int F_DEPTH_DEF = 8;
    localparam int P_SIZE_DEF  = 4;

    // Default almost-full / almost-empty thresholds, in entries
    localparam int AF_LVL_DEF  = 6;
    localparam int AE_LVL_DEF  = 2;

    // Read-port mode encodings
    localparam int RD_MODE_COMB = 0;  // show-ahead, data valid in the read cycle
    localparam int RD_MODE_REG  = 1;  // registered, data valid one cycle later

endpackage : fifo_sync_buf_pkg
`default_nettype wire

// File: rtl/fifo_sync_buf_ram.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_ram
// Description : Storage array for fifo_sync_buf. One synchronous write port,
//               one asynchronous read port. Contents are intentionally not
//               reset; the controller masks anything beyond occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync_ram #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [0:DEPTH-1];

    // Write port: store one word per accepted write
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule : fifo_sync_ram
`default_nettype wire

// File: rtl/fifo_sync_buf.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_buf
// Description : Single-clock FIFO with wrap-bit pointers, occupancy count,
//               almost-full/empty flags, sticky overflow/underflow flags,
//               synchronous flush and selectable combinational/registered
//               read port.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync_buf
    import fifo_sync_buf_pkg::*;
#(
    parameter int D_SIZE  = D_SIZE_DEF,
    parameter int F_DEPTH = F_DEPTH_DEF,
    parameter int P_SIZE  = P_SIZE_DEF,
    parameter int AF_LVL  = AF_LVL_DEF,
    parameter int AE_LVL  = AE_LVL_DEF,
    parameter int RD_REG  = RD_MODE_COMB
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              w_inc,
    input  logic [D_SIZE-1:0] w_data,
    input  logic              r_inc,
    input  logic              flush,
    input  logic              err_clr,
    output logic [D_SIZE-1:0] r_data,
    output logic              r_valid,
    output logic              full,
    output logic              empty,
    output logic              a_full,
    output logic              a_empty,
    output logic [P_SIZE-1:0] count,
    output logic              ovf,
    output logic              udf
);

    localparam int                ADDR_W  = P_SIZE - 1;
    localparam logic [P_SIZE-1:0] PTR_ONE = {{(P_SIZE-1){1'b0}}, 1'b1};
    localparam logic [P_SIZE-1:0] AF_THR  = P_SIZE'(AF_LVL);
    localparam logic [P_SIZE-1:0] AE_THR  = P_SIZE'(AE_LVL);

    logic [P_SIZE-1:0] wptr;
    logic [P_SIZE-1:0] rptr;
    logic              wr_ok;
    logic              rd_ok;
    logic [D_SIZE-1:0] ram_q;

    // Status is a pure function of the registered pointers, so flags carry
    // no extra latency and cannot glitch on request inputs.
    assign empty   = (wptr == rptr);
    assign full    = (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]) &&
                     (wptr[P_SIZE-1]   != rptr[P_SIZE-1]);
    assign count   = wptr - rptr;
    assign a_full  = (count >= AF_THR);
    assign a_empty = (count <= AE_THR);

    // Reset and flush both suppress requests in their cycle
    assign wr_ok = rstn && !flush && w_inc && !full;
    assign rd_ok = rstn && !flush && r_inc && !empty;

    // Pointer update; flush clears both pointers without touching storage
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + PTR_ONE;
            if (rd_ok) rptr <= rptr + PTR_ONE;
        end
    end

    // Sticky error flags; a new error in the same cycle as err_clr wins,
    // and a flush cycle leaves them untouched.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else if (!flush) begin
            if (w_inc && full)      ovf <= 1'b1;
            else if (err_clr)       ovf <= 1'b0;
            if (r_inc && empty)     udf <= 1'b1;
            else if (err_clr)       udf <= 1'b0;
        end
    end

    fifo_sync_ram #(
        .DW (D_SIZE),
        .AW (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we      (wr_ok),
        .addr    (wptr[ADDR_W-1:0]),
        .data    (w_data),
        .rd_addr (rptr[ADDR_W-1:0]),
        .rd_data (ram_q)
    );

    generate
        case (RD_REG)
            RD_MODE_COMB: begin : g_rd_comb
                // Show-ahead: head word visible now, zeroed when nothing is stored
                assign r_data  = empty ? '0 : ram_q;
                assign r_valid = rd_ok;
            end
            default: begin : g_rd_reg
                logic [D_SIZE-1:0] data_q;
                logic              valid_q;

                // Registered read: capture head word on an accepted read
                always_ff @(posedge clk) begin
                    if (!rstn) begin
                        data_q  <= '0;
                        valid_q <= 1'b0;
                    end else begin
                        valid_q <= rd_ok;
                        if (rd_ok) data_q <= ram_q;
                    end
                end

                assign r_data  = data_q;
                assign r_valid = valid_q;
            end
        endcase
    endgenerate

endmodule : fifo_sync_buf
`default_nettype wire

// File: tb/tb_fifo_sync_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_sync_buf
// Description : Self-checking bench for fifo_sync_buf. Two instances (show-
//               ahead and registered read) share stimulus; a queue-based
//               reference model predicts status and read data, and per-DUT
//               monitors compare every presented read word in order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_sync_buf;

    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic       clk = 1'b0;
    logic       rstn, w_inc, r_inc, flush, err_clr;
    logic [7:0] w_data;

    logic [7:0] rd0, rd1;
    logic       rv0, rv1;
    logic       full0, empty0, af0, ae0, ovf0, udf0;
    logic       full1, empty1, af1, ae1, ovf1, udf1;
    logic [3:0] cnt0, cnt1;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [7:0] mq[$];
    logic [7:0] exp0[$];
    logic [7:0] exp1[$];
    bit         ovf_m = 1'b0;
    bit         udf_m = 1'b0;
    bit         check_en = 1'b0;

    always #5 clk = ~clk;

    fifo_sync_buf #(.D_SIZE(8), .F_DEPTH(8), .P_SIZE(4), .AF_LVL(AF), .AE_LVL(AE), .RD_REG(0)) dut0 (
        .clk(clk), .rstn(rstn), .w_inc(w_inc), .w_data(w_data), .r_inc(r_inc),
        .flush(flush), .err_clr(err_clr), .r_data(rd0), .r_valid(rv0),
        .full(full0), .empty(empty0), .a_full(af0), .a_empty(ae0),
        .count(cnt0), .ovf(ovf0), .udf(udf0));

    fifo_sync_buf #(.D_SIZE(8), .F_DEPTH(8), .P_SIZE(4), .AF_LVL(AF), .AE_LVL(AE), .RD_REG(1)) dut1 (
        .clk(clk), .rstn(rstn), .w_inc(w_inc), .w_data(w_data), .r_inc(r_inc),
        .flush(flush), .err_clr(err_clr), .r_data(rd1), .r_valid(rv1),
        .full(full1), .empty(empty1), .a_full(af1), .a_empty(ae1),
        .count(cnt1), .ovf(ovf1), .udf(udf1));

    // Expected status vector {full, empty, a_full, a_empty, count, ovf, udf}
    function automatic logic [9:0] model_status();
        int n;
        n = mq.size();
        return {n == DEPTH, n == 0, n >= AF, n <= AE, 4'(n), ovf_m, udf_m};
    endfunction

    task automatic check_status(input string tag);
        logic [9:0] e, a0, a1;
        e  = model_status();
        a0 = {full0, empty0, af0, ae0, cnt0, ovf0, udf0};
        a1 = {full1, empty1, af1, ae1, cnt1, ovf1, udf1};
        tests++;
        if (a0 !== e || a1 !== e) begin
            fails++;
            $display("FAIL status_%s: comb=%b reg=%b expected=%b (f,e,af,ae,cnt,ovf,udf)",
                     tag, a0, a1, e);
        end
        if (mq.size() == 0) begin
            tests++;
            if (rd0 !== 8'h00) begin
                fails++;
                $display("FAIL empty_rdata_%s: r_data=%h expected=00", tag, rd0);
            end
        end
    endtask

    // One clock of stimulus; the model predicts acceptance from the state
    // before the edge and then advances to the state after it.
    task automatic step(input bit rs, input bit w, input logic [7:0] wd,
                        input bit r, input bit fl, input bit ec, input string tag);
        bit full_m, empty_m, wr_ok, rd_ok;
        logic [7:0] d;
        @(posedge clk); #1;
        rstn = rs; w_inc = w; w_data = wd; r_inc = r; flush = fl; err_clr = ec;
        #1;
        if (check_en) check_status(tag);
        full_m  = (mq.size() == DEPTH);
        empty_m = (mq.size() == 0);
        wr_ok   = rs && !fl && w && !full_m;
        rd_ok   = rs && !fl && r && !empty_m;
        if (rd_ok) begin
            d = mq.pop_front();
            exp0.push_back(d);
            exp1.push_back(d);
        end
        if (wr_ok) mq.push_back(wd);
        if (!rs) begin
            mq.delete();
            ovf_m = 1'b0;
            udf_m = 1'b0;
        end else if (fl) begin
            mq.delete();
        end else begin
            ovf_m = (w && full_m)  ? 1'b1 : (ec ? 1'b0 : ovf_m);
            udf_m = (r && empty_m) ? 1'b1 : (ec ? 1'b0 : udf_m);
        end
    endtask

    // Read-data monitors: each presented word must be the oldest expected one
    always @(negedge clk) begin
        if (rv0 === 1'b1) begin
            tests++;
            if (exp0.size() == 0) begin
                fails++;
                $display("FAIL rd_comb_unexpected: r_valid=1 r_data=%h expected no read", rd0);
            end else begin
                logic [7:0] e;
                e = exp0.pop_front();
                if (rd0 !== e) begin
                    fails++;
                    $display("FAIL rd_comb_data: r_data=%h expected=%h", rd0, e);
                end
            end
        end
        if (rv1 === 1'b1) begin
            tests++;
            if (exp1.size() == 0) begin
                fails++;
                $display("FAIL rd_reg_unexpected: r_valid=1 r_data=%h expected no read", rd1);
            end else begin
                logic [7:0] e;
                e = exp1.pop_front();
                if (rd1 !== e) begin
                    fails++;
                    $display("FAIL rd_reg_data: r_data=%h expected=%h", rd1, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; w_inc = 1'b0; w_data = 8'h00; r_inc = 1'b0;
        flush = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        // Reset values of both instances
        tests++;
        if ({rv0, rv1, rd0, rd1} !== 18'h0) begin
            fails++;
            $display("FAIL reset_rd: rv0=%b rv1=%b rd0=%h rd1=%h expected all zero", rv0, rv1, rd0, rd1);
        end
        check_en = 1'b1;
        check_status("reset");

        // Fill from reset, then one write too many
        for (int i = 1; i <= 9; i++) step(1, 1, 8'(i), 0, 0, 0, "fill");
        // Drain, then one read too many
        for (int i = 0; i < 9; i++) step(1, 0, 8'h00, 1, 0, 0, "drain");
        step(1, 0, 8'h00, 0, 0, 1, "errclr");

        // Wrap: hold occupancy at 5 across many pointer wraps
        for (int i = 0; i < 5; i++) step(1, 1, 8'($urandom), 0, 0, 0, "pre5");
        for (int i = 0; i < 20; i++) step(1, 1, 8'($urandom), 1, 0, 0, "wrap");

        // Simultaneous request at full, then at empty
        for (int i = 0; i < 3; i++) step(1, 1, 8'($urandom), 0, 0, 0, "tofull");
        step(1, 1, 8'hAA, 1, 0, 0, "simfull");
        for (int i = 0; i < 7; i++) step(1, 0, 8'h00, 1, 0, 0, "toempty");
        step(1, 0, 8'h00, 1, 0, 0, "empty0");
        step(1, 1, 8'h55, 1, 0, 0, "simempty");

        // Flush at count 4 keeps sticky errors; err_clr together with a new error
        for (int i = 0; i < 3; i++) step(1, 1, 8'($urandom), 0, 0, 0, "to4");
        step(1, 1, 8'h11, 1, 1, 1, "flush");
        step(1, 0, 8'h00, 1, 0, 1, "clr_vs_udf");
        step(1, 0, 8'h00, 0, 0, 1, "clr");

        // Randomised traffic, write-biased then read-biased, with rare control events
        for (int i = 0; i < 400; i++) begin
            bit w, r, fl, ec, rs;
            w  = (i < 200) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
            r  = (i < 200) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
            fl = ($urandom_range(0, 49) == 0);
            ec = ($urandom_range(0, 19) == 0);
            rs = ($urandom_range(0, 99) != 0);
            step(rs, w, 8'($urandom), r, fl, ec, "rand");
        end

        // Reset in the middle of a burst
        for (int i = 0; i < 5; i++) step(1, 1, 8'($urandom), 1, 0, 0, "burst");
        step(0, 1, 8'hEE, 1, 0, 0, "midrst");
        step(1, 1, 8'h3C, 0, 0, 0, "postrst");
        step(1, 0, 8'h00, 1, 0, 0, "postrd");
        step(1, 0, 8'h00, 0, 0, 0, "idle");
        step(1, 0, 8'h00, 0, 0, 0, "idle");
        @(negedge clk); #1;

        // Every predicted read must have been presented
        tests++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            fails++;
            $display("FAIL pending_reads: comb=%0d reg=%0d outstanding expected=0",
                     exp0.size(), exp1.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_fifo_sync_buf
`default_nettype wire
